// File: rtl/down_counter_pkg.sv
// Shared types and constants for the down_counter_16b block.
package down_counter_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/down_counter_16b.sv
// Loadable down counter with pause/abort and a one-cycle terminal pulse.
// Define DOWN_COUNTER_AUTO_RELOAD_EN to add reload_en and automatic restart from DONE.
module down_counter_16b
    import down_counter_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_value,
    input  logic             pause,
    input  logic             abort,
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
    input  logic             reload_en,
`endif
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             expire
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             expire_q, expire_d;

`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
    logic [WIDTH-1:0] reload_q, reload_d;
`endif

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        expire_d = 1'b0;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
        reload_d = reload_q;
`endif
        case (state_q)
            IDLE: begin
                // abort is deliberately not looked at here: a coincident load wins
                if (load_valid) begin
                    count_d = load_value;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
                    reload_d = load_value;
`endif
                    if (load_value != '0) begin
                        state_d = RUN;
                    end else begin
                        state_d  = DONE;
                        expire_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                    count_d = '0;
                end else if (!pause && count_q != '0) begin
                    count_d = count_q - WIDTH'(1);
                    if (count_q == WIDTH'(1)) begin
                        state_d  = DONE;
                        expire_d = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                count_d = '0;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
                if (!abort && reload_en && reload_q != '0) begin
                    state_d = RUN;
                    count_d = reload_q;
                end
`endif
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            expire_q <= 1'b0;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
            reload_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            expire_q <= expire_d;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
            reload_q <= reload_d;
`endif
        end
    end

    assign load_ready = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign count      = count_q;
    assign expire     = expire_q;

endmodule

// File: tb/tb_down_counter_16b.sv
// Directed self-checking bench for down_counter_16b (reload scenario only when
// DOWN_COUNTER_AUTO_RELOAD_EN is defined).
module tb_down_counter_16b;

    logic        clk;
    logic        rst;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] load_value;
    logic        pause;
    logic        abort;
    logic [15:0] count;
    logic        busy;
    logic        expire;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
    logic        reload_en;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    down_counter_16b #(.WIDTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_value (load_value),
        .pause      (pause),
        .abort      (abort),
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
        .reload_en  (reload_en),
`endif
        .count      (count),
        .busy       (busy),
        .expire     (expire)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [15:0] c, input logic e, input logic b);
        check({tag, "_count"}, 32'(count), 32'(c));
        check({tag, "_expire"}, 32'(expire), 32'(e));
        check({tag, "_busy"}, 32'(busy), 32'(b));
        check({tag, "_ready"}, 32'(load_ready), 32'(!b));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        load_valid = 1'b0;
        load_value = '0;
        pause      = 1'b0;
        abort      = 1'b0;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
        reload_en  = 1'b0;
`endif
        tick();
        tick();
        expect_out("reset", 16'd0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        expect_out("post_reset", 16'd0, 1'b0, 1'b0);

        // N=5: expire in the cycle after the 5th edge past E0
        load_valid = 1'b1; load_value = 16'd5;
        tick();
        load_valid = 1'b0;
        expect_out("n5_e0", 16'd5, 1'b0, 1'b1);
        for (int i = 4; i >= 0; i--) begin
            tick();
            expect_out("n5_run", 16'(i), (i == 0), 1'b1);
        end
        tick();
        expect_out("n5_idle", 16'd0, 1'b0, 1'b0);

        // N=0 with pause high: DONE at E0, pause has no effect
        load_valid = 1'b1; load_value = 16'd0; pause = 1'b1;
        tick();
        load_valid = 1'b0;
        expect_out("n0_done", 16'd0, 1'b1, 1'b1);
        tick();
        pause = 1'b0;
        expect_out("n0_idle", 16'd0, 1'b0, 1'b0);

        // N=4, pause 3 cycles at count=2
        load_valid = 1'b1; load_value = 16'd4;
        tick();
        load_valid = 1'b0;
        expect_out("n4_e0", 16'd4, 1'b0, 1'b1);
        tick(); expect_out("n4_3", 16'd3, 1'b0, 1'b1);
        tick(); expect_out("n4_2", 16'd2, 1'b0, 1'b1);
        pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_out("n4_hold", 16'd2, 1'b0, 1'b1);
        end
        pause = 1'b0;
        tick(); expect_out("n4_1", 16'd1, 1'b0, 1'b1);
        tick(); expect_out("n4_exp", 16'd0, 1'b1, 1'b1);
        tick(); expect_out("n4_idle", 16'd0, 1'b0, 1'b0);

        // N=10, abort together with pause at count=6
        load_valid = 1'b1; load_value = 16'd10;
        tick();
        load_valid = 1'b0;
        expect_out("n10_e0", 16'd10, 1'b0, 1'b1);
        for (int i = 9; i >= 6; i--) begin
            tick();
            expect_out("n10_run", 16'(i), 1'b0, 1'b1);
        end
        abort = 1'b1; pause = 1'b1;
        tick();
        pause = 1'b0;
        expect_out("n10_abort", 16'd0, 1'b0, 1'b0);

        // abort with load in IDLE: the load wins
        load_valid = 1'b1; load_value = 16'd3;
        tick();
        abort = 1'b0; load_valid = 1'b0;
        expect_out("abort_load", 16'd3, 1'b0, 1'b1);
        tick(); expect_out("al_2", 16'd2, 1'b0, 1'b1);
        tick(); expect_out("al_1", 16'd1, 1'b0, 1'b1);
        // request held across busy waits for the first IDLE cycle
        load_valid = 1'b1; load_value = 16'd7;
        tick(); expect_out("hold_done", 16'd0, 1'b1, 1'b1);
        tick(); expect_out("hold_idle", 16'd0, 1'b0, 1'b0);
        tick(); expect_out("hold_acc", 16'd7, 1'b0, 1'b1);
        load_valid = 1'b0; abort = 1'b1;
        tick();
        abort = 1'b0;
        expect_out("hold_abort", 16'd0, 1'b0, 1'b0);

        // abort while in DONE
        load_valid = 1'b1; load_value = 16'd1;
        tick();
        load_valid = 1'b0;
        expect_out("n1_e0", 16'd1, 1'b0, 1'b1);
        tick(); expect_out("n1_done", 16'd0, 1'b1, 1'b1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        expect_out("n1_abort", 16'd0, 1'b0, 1'b0);

        // full-scale load: no overflow on the first decrement
        load_valid = 1'b1; load_value = 16'hFFFF;
        tick();
        load_valid = 1'b0;
        expect_out("max_e0", 16'hFFFF, 1'b0, 1'b1);
        tick(); expect_out("max_dec", 16'hFFFE, 1'b0, 1'b1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        expect_out("max_abort", 16'd0, 1'b0, 1'b0);

        // N=8, asynchronous reset at count=3
        load_valid = 1'b1; load_value = 16'd8;
        tick();
        load_valid = 1'b0;
        expect_out("n8_e0", 16'd8, 1'b0, 1'b1);
        for (int i = 7; i >= 3; i--) begin
            tick();
            expect_out("n8_run", 16'(i), 1'b0, 1'b1);
        end
        #2 rst = 1'b1;
        #1 expect_out("rst_async", 16'd0, 1'b0, 1'b0);
        load_valid = 1'b1; load_value = 16'd2;
        @(negedge clk);
        rst = 1'b0;
        tick();
        load_valid = 1'b0;
        expect_out("rst_load", 16'd2, 1'b0, 1'b1);
        tick(); expect_out("rst_1", 16'd1, 1'b0, 1'b1);
        tick(); expect_out("rst_exp", 16'd0, 1'b1, 1'b1);
        tick(); expect_out("rst_idle", 16'd0, 1'b0, 1'b0);

`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
        // N=3 with reload: expire every 4 cycles, stop after reload_en drops
        reload_en = 1'b1;
        load_valid = 1'b1; load_value = 16'd3;
        tick();
        load_valid = 1'b0;
        expect_out("rl_e0", 16'd3, 1'b0, 1'b1);
        for (int r = 0; r < 2; r++) begin
            tick(); expect_out("rl_2", 16'd2, 1'b0, 1'b1);
            tick(); expect_out("rl_1", 16'd1, 1'b0, 1'b1);
            tick(); expect_out("rl_exp", 16'd0, 1'b1, 1'b1);
            tick(); expect_out("rl_reload", 16'd3, 1'b0, 1'b1);
        end
        reload_en = 1'b0;
        tick(); expect_out("rl_off_2", 16'd2, 1'b0, 1'b1);
        tick(); expect_out("rl_off_1", 16'd1, 1'b0, 1'b1);
        tick(); expect_out("rl_off_exp", 16'd0, 1'b1, 1'b1);
        tick(); expect_out("rl_off_idle", 16'd0, 1'b0, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
